// File: rtl/issue_scoreboard.sv
// N-lane in-order issue gate for the ID stage.
// A per-register load countdown holds dependents; a halt FSM drains the pipe.
module issue_scoreboard #(
    parameter int NUM_LANES = 2,
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int MEM_PORTS = 1,
    parameter int CNT_W     = 3,
    localparam int IC_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       id_valid,
    input  logic [NUM_LANES*REG_W-1:0] id_rs,
    input  logic [NUM_LANES*REG_W-1:0] id_rt,
    input  logic [NUM_LANES-1:0]       id_rt_used,
    input  logic [NUM_LANES-1:0]       id_we,
    input  logic [NUM_LANES*REG_W-1:0] id_wr_reg,
    input  logic [NUM_LANES-1:0]       id_is_load,
    input  logic [NUM_LANES-1:0]       id_is_mem,
    input  logic                       flush,
    input  logic                       halt_req,
    output logic [NUM_LANES-1:0]       id_issue,
    output logic [IC_W-1:0]            issue_cnt,
    output logic                       fetch_en,
    output logic                       halted,
    output logic [15:0]                stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [15:0]         stall_q;
    logic                stall_inc;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // Issue is a prefix of ready lanes; memory ports are consumed in lane order.
    always_comb begin
        logic             chain;
        logic             blk;
        logic [REG_W-1:0] rs, rt, wj;
        int               mem_used;
        id_issue = '0;
        chain    = ~rst & ~flush & (state_q == RUN);
        mem_used = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rs  = id_rs[i*REG_W +: REG_W];
            rt  = id_rt[i*REG_W +: REG_W];
            blk = ~id_valid[i];
            if (rs != '0 && busy[rs]) blk = 1'b1;
            if (id_rt_used[i] && rt != '0 && busy[rt]) blk = 1'b1;
            for (int j = 0; j < NUM_LANES; j++) begin
                wj = id_wr_reg[j*REG_W +: REG_W];
                if (j < i && id_we[j]) begin
                    if (rs != '0 && wj == rs) blk = 1'b1;
                    if (id_rt_used[i] && rt != '0 && wj == rt) blk = 1'b1;
                end
            end
            if (id_is_mem[i] && mem_used >= MEM_PORTS) blk = 1'b1;
            chain       = chain & ~blk;
            id_issue[i] = chain;
            if (chain && id_is_mem[i]) mem_used = mem_used + 1;
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            issue_cnt = issue_cnt + IC_W'(id_issue[i]);
        end
    end

    assign fetch_en  = ~rst & (id_issue == id_valid) & ~flush
                     & (state_q == RUN);
    assign halted    = (state_q == HALTED);
    assign stall_inc = (state_q == RUN) & ~flush
                     & ((id_valid & ~id_issue) != '0);
    assign stall_cycles = stall_q;

    // Loop order makes the youngest issuing writer win on same-bundle WAW.
    always_comb begin
        logic [REG_W-1:0] wr;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (flush || !busy[r]) ? '0 : cnt_q[r] - 1'b1;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            wr = id_wr_reg[i*REG_W +: REG_W];
            if (id_issue[i] && id_we[i] && wr != '0) begin
                cnt_d[wr] = id_is_load[i] ? CNT_W'(LOAD_LAT) : '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (halt_req) state_d = DRAIN;
            DRAIN:   if (busy == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (stall_inc && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and random bench for issue_scoreboard against a
// timestamp-based reference model of register availability.
module tb_issue_scoreboard;

    localparam int NL  = 2;
    localparam int RW  = 5;
    localparam int NR  = 32;
    localparam int LL  = 1;
    localparam int MPT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] id_valid, id_rt_used, id_we, id_is_load, id_is_mem;
    logic [NL*RW-1:0] id_rs, id_rt, id_wr_reg;
    logic          flush, halt_req;
    logic [NL-1:0] id_issue;
    logic [1:0]    issue_cnt;
    logic          fetch_en, halted;
    logic [15:0]   stall_cycles;

    int tests = 0;
    int fails = 0;

    // Model: cycle at which each register becomes readable.
    longint cyc = 0;
    longint ready_at [NR];
    int     mstate = 0;
    int     mstall = 0;

    logic [NL-1:0] last_issue;
    logic          last_fetch;
    logic          last_halted;
    logic [15:0]   last_stall;

    issue_scoreboard #(
        .NUM_LANES(NL), .NUM_REGS(NR), .REG_W(RW),
        .LOAD_LAT(LL), .MEM_PORTS(MPT), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rt_used(id_rt_used), .id_we(id_we),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
        .id_is_mem(id_is_mem), .flush(flush),
        .halt_req(halt_req), .id_issue(id_issue),
        .issue_cnt(issue_cnt), .fetch_en(fetch_en),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fld(logic [NL*RW-1:0] v, int i);
        return int'(v[i*RW +: RW]);
    endfunction

    function automatic bit src_busy(int s, int i);
        if (s == 0) return 0;
        if (ready_at[s] > cyc) return 1;
        for (int j = 0; j < i; j++)
            if (id_we[j] && fld(id_wr_reg, j) == s) return 1;
        return 0;
    endfunction

    function automatic logic [NL-1:0] model_issue();
        logic [NL-1:0] e = '0;
        int memn = 0;
        if (rst || flush || mstate != 0) return e;
        for (int i = 0; i < NL; i++) begin
            if (!id_valid[i]) return e;
            if (src_busy(fld(id_rs, i), i)) return e;
            if (id_rt_used[i] && src_busy(fld(id_rt, i), i)) return e;
            if (id_is_mem[i] && memn >= MPT) return e;
            e[i] = 1'b1;
            if (id_is_mem[i]) memn++;
        end
        return e;
    endfunction

    task automatic model_edge(logic [NL-1:0] e);
        bit drained = 1;
        if (rst) begin
            foreach (ready_at[r]) ready_at[r] = 0;
            mstate = 0;
            mstall = 0;
        end else begin
            for (int r = 1; r < NR; r++)
                if (ready_at[r] > cyc) drained = 0;
            if (mstate == 0 && !flush && (id_valid & ~e) != 0
                && mstall < 65535) mstall++;
            if (flush) begin
                foreach (ready_at[r]) ready_at[r] = cyc + 1;
            end else begin
                for (int i = 0; i < NL; i++)
                    if (e[i] && id_we[i] && fld(id_wr_reg, i) != 0)
                        ready_at[fld(id_wr_reg, i)] =
                            cyc + 1 + (id_is_load[i] ? LL : 0);
            end
            if (mstate == 0 && halt_req) mstate = 1;
            else if (mstate == 1 && drained) mstate = 2;
        end
        cyc++;
    endtask

    task automatic step();
        logic [NL-1:0] e;
        int ecnt;
        @(negedge clk);
        e    = model_issue();
        ecnt = $countones(e);
        chk("id_issue", id_issue, e);
        chk("issue_cnt", issue_cnt, ecnt);
        chk("fetch_en", fetch_en,
            !rst && e == id_valid && !flush && mstate == 0);
        chk("halted", halted, mstate == 2);
        chk("stall_cycles", stall_cycles, mstall);
        last_issue  = id_issue;
        last_fetch  = fetch_en;
        last_halted = halted;
        last_stall  = stall_cycles;
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    task automatic clear_in();
        id_valid = '0; id_rs = '0; id_rt = '0; id_rt_used = '0;
        id_we = '0; id_wr_reg = '0; id_is_load = '0; id_is_mem = '0;
        flush = 0; halt_req = 0;
    endtask

    task automatic set_lane(int i, bit v, int rs, int rt, bit ru,
                            bit we, int wr, bit ld, bit mem);
        id_valid[i]        = v;
        id_rs[i*RW +: RW]  = RW'(rs);
        id_rt[i*RW +: RW]  = RW'(rt);
        id_rt_used[i]      = ru;
        id_we[i]           = we;
        id_wr_reg[i*RW +: RW] = RW'(wr);
        id_is_load[i]      = ld;
        id_is_mem[i]       = mem;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        set_lane(0, 1, 1, 0, 0, 1, 2, 0, 0);
        step();
        chk("rst_issue", last_issue, 0);
        chk("rst_fetch", last_fetch, 0);
        rst = 0;
        clear_in();
    endtask

    initial begin
        foreach (ready_at[r]) ready_at[r] = 0;
        clear_in();
        rst = 1;
        step();
        do_reset();
        step();
        chk("reset_stall", last_stall, 0);
        chk("reset_halted", last_halted, 0);

        // Load-use hold of one cycle
        set_lane(0, 1, 1, 0, 0, 1, 8, 1, 1);
        step();
        set_lane(0, 1, 8, 0, 0, 1, 9, 0, 0);
        step();
        chk("t1_hold", last_issue, 2'b00);
        step();
        chk("t1_issue", last_issue, 2'b01);
        chk("t1_stall", last_stall, 1);
        clear_in();
        step();

        // Intra-bundle RAW splits the bundle
        set_lane(0, 1, 1, 0, 0, 1, 3, 0, 0);
        set_lane(1, 1, 3, 4, 1, 1, 5, 0, 0);
        step();
        chk("t2_issue", last_issue, 2'b01);
        chk("t2_fetch", last_fetch, 0);
        clear_in();
        set_lane(0, 1, 3, 4, 1, 1, 5, 0, 0);
        step();
        chk("t2_next", last_issue, 2'b01);
        chk("t2_fetch_next", last_fetch, 1);

        // Memory port conflict, then a held oldest lane
        clear_in();
        set_lane(0, 1, 2, 0, 0, 1, 6, 1, 1);
        set_lane(1, 1, 2, 7, 1, 0, 0, 0, 1);
        step();
        chk("t3_mem", last_issue, 2'b01);
        clear_in();
        set_lane(0, 1, 6, 0, 0, 1, 10, 0, 0);
        set_lane(1, 1, 1, 0, 0, 1, 11, 0, 0);
        step();
        chk("t3_held", last_issue, 2'b00);
        clear_in();
        step();

        // Flush clears a pending load
        set_lane(0, 1, 1, 0, 0, 1, 5, 1, 1);
        step();
        clear_in();
        set_lane(0, 1, 5, 0, 0, 1, 12, 0, 0);
        flush = 1;
        step();
        chk("t4_flush", last_issue, 2'b00);
        flush = 0;
        step();
        chk("t4_after", last_issue, 2'b01);

        // Same-bundle WAW: younger non-load wins
        clear_in();
        set_lane(0, 1, 1, 0, 0, 1, 4, 1, 1);
        set_lane(1, 1, 1, 0, 0, 1, 4, 0, 0);
        step();
        chk("t5_bundle", last_issue, 2'b11);
        clear_in();
        set_lane(0, 1, 4, 0, 0, 1, 13, 0, 0);
        step();
        chk("t5_reader", last_issue, 2'b01);

        // Random traffic on a small register window
        for (int n = 0; n < 400; n++) begin
            clear_in();
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < NL; i++) begin
                bit mem = $urandom_range(0, 2) == 0;
                bit ld  = mem & $urandom_range(0, 1);
                set_lane(i, $urandom_range(0, 5) != 0,
                         $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 1), ld | ($urandom_range(0, 2) != 0),
                         $urandom_range(0, 7), ld, mem);
            end
            step();
        end
        rst = 0;
        do_reset();

        // Halt drains a pending load before halting
        set_lane(0, 1, 1, 0, 0, 1, 9, 1, 1);
        halt_req = 1;
        step();
        halt_req = 0;
        set_lane(0, 1, 1, 0, 0, 1, 14, 0, 0);
        step();
        chk("t6_drain1", last_issue, 2'b00);
        chk("t6_drain1_h", last_halted, 0);
        step();
        chk("t6_drain2", last_issue, 2'b00);
        chk("t6_drain2_h", last_halted, 0);
        halt_req = 1;
        step();
        chk("t6_halted", last_halted, 1);
        chk("t6_fetch", last_fetch, 0);
        step();
        chk("t6_hold", last_halted, 1);
        do_reset();
        set_lane(0, 1, 1, 0, 0, 1, 14, 0, 0);
        step();
        chk("t6_rst_halted", last_halted, 0);
        chk("t6_rst_issue", last_issue, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
